dir_input_conditioner: RTL

Front end for the adventure game: conditions four raw push-button inputs into the clean, single-cycle, mutually exclusive `n`/`s`/`e`/`w` move pulses consumed by the game core. Each button is synchronised and debounced. Rising edges are arbitrated so exactly one move is issued per press. Further moves are locked out until all buttons are released. Sits directly upstream of the game core's direction inputs.

---
 rtl/game_pkg.sv | 36 +++
 rtl/button_debounce.sv | 52 +++++
 rtl/dir_input_conditioner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the adventure game front end.
// Direction and arbiter encodings plus one-hot helpers.
package game_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } arb_state_e;

  // Fixed priority N > S > E > W; bit i of r is direction i.
  function automatic dir_e pick_dir(logic [3:0] r);
    dir_e d;
    d = DIR_W;
    priority case (1'b1)
      r[0]: d = DIR_N;
      r[1]: d = DIR_S;
      r[2]: d = DIR_E;
      default: d = DIR_W;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] dir_onehot(dir_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce counter, stable level.
// Emits the stable level and a one-cycle rising-edge strobe.
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable_q;
  logic                   lvl;

  assign lvl  = sync[SYNC_STAGES-1];
  assign rise = stable & ~stable_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], btn};
  end

  // Accept a new level only after it persists DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (lvl == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      stable <= lvl;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the stable level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) stable_q <= 1'b0;
    else       stable_q <= stable;
  end

endmodule

// File: rtl/dir_input_conditioner.sv
// Buttons -> debounced, arbitrated one-cycle n/s/e/w move pulses.
// Optional auto-repeat while held: define REPEAT_EN.
module dir_input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic enable,
  output logic n,
  output logic s,
  output logic e,
  output logic w
);

  logic [3:0] btn;
  logic [3:0] stable;
  logic [3:0] rise;
  logic [3:0] pulse_d;

  arb_state_e state_q, state_d;

  assign btn = {btn_w, btn_e, btn_s, btn_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

`ifdef REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  dir_e          dir_q, dir_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rphase_q, rphase_d;
  logic          rstop_q, rstop_d;
  logic [RW-1:0] rlim;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rlim = rphase_q ? RW'(REPEAT_PERIOD - 1) :
                           RW'(REPEAT_DELAY - 1);

  // Latched winner and repeat timing state.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q    <= DIR_N;
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
      rstop_q  <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
      rstop_q  <= rstop_d;
    end
  end
`endif

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, winner selection and pulse generation.
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
`ifdef REPEAT_EN
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    rstop_d  = rstop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|rise) begin
          state_d = HELD;
          pulse_d = dir_onehot(pick_dir(rise));
`ifdef REPEAT_EN
          dir_d    = pick_dir(rise);
          rcnt_d   = '0;
          rphase_d = 1'b0;
          rstop_d  = 1'b0;
`endif
        end
      end
      HELD: begin
        if (stable == 4'b0000) begin
          state_d = IDLE;
        end
`ifdef REPEAT_EN
        // Once the latched button lets go, repeats stay off.
        if (!rstop_q) begin
          if (!stable[dir_q]) begin
            rstop_d = 1'b1;
          end else if (rcnt_q == rlim) begin
            pulse_d  = dir_onehot(dir_q);
            rcnt_d   = '0;
            rphase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    pulse_d = pulse_d & {4{enable}};
  end

  // Registered move pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= 1'b0;
      s <= 1'b0;
      e <= 1'b0;
      w <= 1'b0;
    end else begin
      n <= pulse_d[0];
      s <= pulse_d[1];
      e <= pulse_d[2];
      w <= pulse_d[3];
    end
  end

endmodule
